// File: rtl/ps2_host_cmd.sv
// -----------------------------------------------------------------------------
// ps2_host_cmd
//   Host-to-device command controller for a PS/2 keyboard port. Two command
//   requesters share the port through a round-robin arbiter. Each accepted
//   byte is sent as one frame:
//     1. Hold the clock low (inhibit) while asserting the start bit in the
//        final inhibit cycle.
//     2. Release the clock and shift data, parity and stop on device falling
//        edges.
//     3. Sample the device ACK bit on the 11th edge.
//     4. Wait for the 0xFA (ack) or 0xFE (resend) response byte.
//   The receive path is gated while the host owns the lines.
//
// Build option:
//   PS2_RETRY_EN - when defined, 0xFE triggers up to MAX_RETRY re-sends of the
//                  same byte. When undefined, 0xFE ends the transfer at once,
//                  and neither the retry counter nor MAX_RETRY exists.
//
// Ports:
//   clk25                 25 MHz system clock
//   rst_n                 synchronous reset, active low
//   key_clk_db            debounced PS/2 clock level
//   key_din               PS/2 data level (ACK bit sampling)
//   clk_oe, dat_oe        open-drain pull-down enables for clock/data
//   rx_gate               receiver must discard bits while high
//   rx_valid, rx_data     received byte strobe and value
//   reqN_valid/data       command request from requester N (N = 0, 1)
//   reqN_ready            combinational accept for requester N
//   busy                  transfer in progress
//   done                  one-cycle pulse at transfer end
//   status                00 ok, 01 resend fail, 10 timeout, 11 no ACK bit
//   grant_id              requester of the current/last transfer
// -----------------------------------------------------------------------------
module ps2_host_cmd #(
  parameter int INHIBIT_CYC = 2500,   // must be >= 2
  parameter int TIMEOUT_CYC = 500000
`ifdef PS2_RETRY_EN
  ,
  parameter int MAX_RETRY   = 2
`endif
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       key_clk_db,
  input  logic       key_din,
  output logic       clk_oe,
  output logic       dat_oe,
  output logic       rx_gate,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic       grant_id
);

  localparam int CNT_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYC - 2);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_RTS      = 3'd2,
    S_WAITRESP = 3'd3,
    S_END      = 3'd4
  } state_e;

  state_e          state_q,    state_d;
  logic [CW-1:0]   cnt_q,      cnt_d;      // inhibit length, then timeout
  logic [3:0]      edge_q,     edge_d;     // falling edges seen in RTS
  logic [7:0]      byte_q,     byte_d;
  logic            par_q,      par_d;
  logic            prev_clk_q;
  logic            last_gnt_q, last_gnt_d;
  logic            grant_id_q, grant_id_d;
  logic [1:0]      status_q,   status_d;
  logic            done_q,     done_d;
  logic            clk_oe_q,   clk_oe_d;
  logic            dat_oe_q,   dat_oe_d;
  logic            busy_q,     busy_d;
  logic            rx_gate_q,  rx_gate_d;
`ifdef PS2_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0]   retry_q,    retry_d;
`endif

  logic          fall_s;
  logic          to_hit_s;
  logic [CW-1:0] cnt_sat_s;
  logic          gnt0_s, gnt1_s;
  logic [7:0]    sel_byte_s;
  logic [3:0]    edge_nxt_s;

  assign fall_s     = prev_clk_q & ~key_clk_db;
  assign to_hit_s   = (cnt_q == TO_LAST);
  // Saturate at the last count so an edge/byte that wins a tie against the
  // timeout still leaves the timeout armed for the following cycle.
  assign cnt_sat_s  = to_hit_s ? cnt_q : (cnt_q + CW'(1));
  assign edge_nxt_s = edge_q + 4'd1;

  // Round-robin: on a tie, the requester not granted last time wins.
  assign gnt0_s     = req0_valid & (~req1_valid | last_gnt_q);
  assign gnt1_s     = req1_valid & (~req0_valid | ~last_gnt_q);
  assign req0_ready = (state_q == S_IDLE) & gnt0_s;
  assign req1_ready = (state_q == S_IDLE) & gnt1_s;
  assign sel_byte_s = gnt1_s ? req1_data : req0_data;

  assign clk_oe   = clk_oe_q;
  assign dat_oe   = dat_oe_q;
  assign rx_gate  = rx_gate_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign status   = status_q;
  assign grant_id = grant_id_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    byte_d     = byte_q;
    par_d      = par_q;
    last_gnt_d = last_gnt_q;
    grant_id_d = grant_id_q;
    status_d   = status_q;
    dat_oe_d   = dat_oe_q;
`ifdef PS2_RETRY_EN
    retry_d    = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        dat_oe_d = 1'b0;
        if (req0_ready || req1_ready) begin
          state_d    = S_INHIBIT;
          cnt_d      = '0;
          byte_d     = sel_byte_s;
          par_d      = ~^sel_byte_s;           // odd parity bit
          grant_id_d = gnt1_s;
          last_gnt_d = gnt1_s;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d  = S_RTS;
          cnt_d    = '0;                        // timeout starts at release
          edge_d   = 4'd0;
          dat_oe_d = 1'b1;                      // start bit stays asserted
        end else begin
          cnt_d    = cnt_q + CW'(1);
          dat_oe_d = (cnt_q == INH_START);      // start bit in last inhibit cycle
        end
      end

      S_RTS: begin
        if (fall_s) begin
          edge_d = edge_nxt_s;
          cnt_d  = cnt_sat_s;
          if (edge_nxt_s <= 4'd8) begin
            dat_oe_d = ~byte_q[edge_q[2:0]];    // LSB first
          end else if (edge_nxt_s == 4'd9) begin
            dat_oe_d = ~par_q;
          end else if (edge_nxt_s == 4'd10) begin
            dat_oe_d = 1'b0;                    // stop bit: line released
          end else begin
            dat_oe_d = 1'b0;
            if (key_din) begin
              state_d  = S_END;
              status_d = 2'b11;
            end else begin
              state_d  = S_WAITRESP;
            end
          end
        end else if (to_hit_s) begin
          state_d  = S_END;
          status_d = 2'b10;
          dat_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WAITRESP: begin
        dat_oe_d = 1'b0;
        if (rx_valid && (rx_data == 8'hFA)) begin
          state_d  = S_END;
          status_d = 2'b00;
        end else if (rx_valid && (rx_data == 8'hFE)) begin
`ifdef PS2_RETRY_EN
          if (retry_q < RW'(MAX_RETRY)) begin
            state_d = S_INHIBIT;
            cnt_d   = '0;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d  = S_END;
            status_d = 2'b01;
          end
`else
          state_d  = S_END;
          status_d = 2'b01;
`endif
        end else if (to_hit_s) begin
          state_d  = S_END;
          status_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_END: begin
        state_d  = S_IDLE;
        dat_oe_d = 1'b0;
`ifdef PS2_RETRY_EN
        retry_d  = '0;
`endif
      end

      default: begin
        state_d  = S_IDLE;
        dat_oe_d = 1'b0;
      end
    endcase

    // Line/status outputs are registered from the next state.
    clk_oe_d  = (state_d == S_INHIBIT);
    busy_d    = (state_d != S_IDLE);
    rx_gate_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
    done_d    = (state_d == S_END);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= 4'd0;
      byte_q     <= 8'h00;
      par_q      <= 1'b0;
      prev_clk_q <= 1'b1;
      last_gnt_q <= 1'b1;
      grant_id_q <= 1'b0;
      status_q   <= 2'b00;
      done_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_gate_q  <= 1'b0;
`ifdef PS2_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      prev_clk_q <= key_clk_db;
      last_gnt_q <= last_gnt_d;
      grant_id_q <= grant_id_d;
      status_q   <= status_d;
      done_q     <= done_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      rx_gate_q  <= rx_gate_d;
`ifdef PS2_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

endmodule
